jogo_sequencia_param: RTL
=========================

// Module: jogo_sequencia_param
// PURPOSE
//   Parametrised sequence-check game: compares player inputs against a DATA_W-wide sequence from an external ROM.
//   The sequence length is set at run time. Each play is triggered by a button edge.
//   A per-play timeout ends the game if no play arrives in time.
//   Result and state codes feed the hexa7seg displays at top level.
// PARAMETERS
//   DATA_W   4      width of chaves / memory word
//   DEPTH    16     ROM entries; ADDR_W = $clog2(DEPTH) (local)
//   TIMEOUT  5000   clock cycles allowed per play while waiting (>=2)
// PORTS
//   clock         in   1       system clock, rising edge
//   reset         in   1       asynchronous, active-low; 0 forces all state/outputs to reset values
//   iniciar       in   1       start/restart request (level, sampled each cycle)
//   jogada        in   1       play button (level, synchronous); rising edge = one play
//   chaves        in   DATA_W  player value
//   limite        in   ADDR_W  index of last entry to check; sampled in PREPARA
//   mem_dado      in   DATA_W  ROM word at mem_endereco (combinational read)
//   mem_endereco  out  ADDR_W  current sequence index
//   pronto        out  1       high while in any FIM_* state
//   acertou       out  1       high in FIM_ACERTO
//   errou         out  1       high in FIM_ERRO or FIM_TIMEOUT
//   timeout       out  1       high in FIM_TIMEOUT only
//   db_igual      out  1       combinational: jogada register == mem_dado
//   db_jogada     out  DATA_W  last captured chaves value
//   db_estado     out  4       state code, see table below
//   db_resultado  out  4       hex code: A=acertou, E=errou, C=timeout, 0=otherwise
// BEHAVIOUR
//   Reset (reset=0): state INICIAL.
//     - mem_endereco=0, db_jogada=0, timeout counter=0, limite register=0, edge-detect flop=0.
//     - pronto/acertou/errou/timeout=0; db_resultado=0.
//   State codes:
//     INICIAL=0, PREPARA=1, ESPERA=2, REGISTRA=4, COMPARA=5, PROXIMO=6,
//     FIM_ACERTO=A, FIM_ERRO=E, FIM_TIMEOUT=C.
//   Transitions:
//     - INICIAL: iniciar=1 -> PREPARA.
//     - PREPARA (1 cycle): clear address, jogada register and timeout counter; latch limite -> ESPERA.
//     - ESPERA:
//         - jogada rising edge -> REGISTRA. Edge = jogada & ~jogada_q, with jogada_q a one-cycle delay flop.
//         - Otherwise the counter increments. When it reaches TIMEOUT-1 -> FIM_TIMEOUT.
//         - The edge has priority over timeout in the same cycle.
//     - REGISTRA (1 cycle): capture chaves into db_jogada -> COMPARA.
//     - COMPARA:
//         - not equal -> FIM_ERRO;
//         - equal and address==limite -> FIM_ACERTO;
//         - equal otherwise -> PROXIMO.
//     - PROXIMO (1 cycle): address+1, clear timeout counter -> ESPERA.
//     - FIM_*: hold outputs and address. iniciar=1 -> PREPARA (restart without reset).
//   Latency: edge seen in ESPERA at cycle n -> db_jogada valid at n+2 -> FIM_* or PROXIMO at n+3.
//   Flags and pronto are Moore outputs decoded from state; no glitch-free requirement beyond that.
//   Address never exceeds limite, so no wrap occurs. limite >= DEPTH cannot occur by construction (ADDR_W bits).
//   limite=0: single-entry game.
//   Button held high across states produces no second play until released and pressed again.
//   iniciar is ignored outside INICIAL and FIM_*.
//   reset asserted mid-game: immediate return to INICIAL with reset values, no residual flags.
// TESTING
//   1 reset=0, then release; ROM={3,7,1,...}; limite=2; play 3,7,1 -> FIM_ACERTO, acertou=1, db_resultado=A, mem_endereco=2.
//   2 Same ROM; play 3 then 5 -> FIM_ERRO after 2nd play, errou=1, db_jogada=5, mem_endereco=1.
//   3 TIMEOUT=20; no jogada after start -> FIM_TIMEOUT exactly 20 cycles after entering ESPERA; timeout=errou=1, db_resultado=C.
//   4 Hold jogada=1 for 50 cycles with correct value -> exactly one play counted (address advances by 1 only).
//   5 In FIM_ERRO assert iniciar -> PREPARA; flags clear, address=0; a new full correct game ends in FIM_ACERTO.
//   6 reset=0 during ESPERA at address 1 -> same cycle all outputs at reset values, db_estado=0.

Source files
------------

// File: rtl/jogo_sequencia_param.sv
// rtl/jogo_sequencia_param.sv - sequence-check game: player plays compared against an external ROM sequence
module jogo_sequencia_param #(
    parameter int  DATA_W  = 4,
    parameter int  DEPTH   = 16,
    parameter int  TIMEOUT = 5000,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic              jogada,
    input  logic [DATA_W-1:0] chaves,
    input  logic [ADDR_W-1:0] limite,
    input  logic [DATA_W-1:0] mem_dado,
    output logic [ADDR_W-1:0] mem_endereco,
    output logic              pronto,
    output logic              acertou,
    output logic              errou,
    output logic              timeout,
    output logic              db_igual,
    output logic [DATA_W-1:0] db_jogada,
    output logic [3:0]        db_estado,
    output logic [3:0]        db_resultado
);

    // Counter only has to reach TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
    localparam int              CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    // State encoding doubles as the debug code shown on the 7-segment display.
    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARA     = 4'h1,
        ESPERA      = 4'h2,
        REGISTRA    = 4'h4,
        COMPARA     = 4'h5,
        PROXIMO     = 4'h6,
        FIM_ACERTO  = 4'hA,
        FIM_ERRO    = 4'hE,
        FIM_TIMEOUT = 4'hC
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              jogada_q;
    logic              jogada_edge;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] limite_q;
    logic              counter_done;
    logic              fim_next;

    assign jogada_edge  = jogada & ~jogada_q;
    assign counter_done = (cnt == CNT_LAST);
    assign db_igual     = (db_jogada == mem_dado);
    assign db_estado    = state;
    assign fim_next     = (state_next == FIM_ACERTO) || (state_next == FIM_ERRO) ||
                          (state_next == FIM_TIMEOUT);

    // Next-state decision; a play edge wins over an expiring timeout in the same cycle.
    always_comb begin
        state_next = state;
        case (state)
            INICIAL:     if (iniciar) state_next = PREPARA;
            PREPARA:     state_next = ESPERA;
            ESPERA: begin
                if (jogada_edge)       state_next = REGISTRA;
                else if (counter_done) state_next = FIM_TIMEOUT;
            end
            REGISTRA:    state_next = COMPARA;
            COMPARA: begin
                if (db_jogada != mem_dado)      state_next = FIM_ERRO;
                else if (mem_endereco == limite_q) state_next = FIM_ACERTO;
                else                            state_next = PROXIMO;
            end
            PROXIMO:     state_next = ESPERA;
            FIM_ACERTO,
            FIM_ERRO,
            FIM_TIMEOUT: if (iniciar) state_next = PREPARA;
            default:     state_next = INICIAL;
        endcase
    end

    // State register with Moore flags registered from the upcoming state so they track it exactly.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= INICIAL;
            pronto       <= 1'b0;
            acertou      <= 1'b0;
            errou        <= 1'b0;
            timeout      <= 1'b0;
            db_resultado <= 4'h0;
        end else begin
            state   <= state_next;
            pronto  <= fim_next;
            acertou <= (state_next == FIM_ACERTO);
            errou   <= (state_next == FIM_ERRO) || (state_next == FIM_TIMEOUT);
            timeout <= (state_next == FIM_TIMEOUT);
            case (state_next)
                FIM_ACERTO:  db_resultado <= 4'hA;
                FIM_ERRO:    db_resultado <= 4'hE;
                FIM_TIMEOUT: db_resultado <= 4'hC;
                default:     db_resultado <= 4'h0;
            endcase
        end
    end

    // Button delay flop: runs in every state so a held button never re-triggers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) jogada_q <= 1'b0;
        else        jogada_q <= jogada;
    end

    // Datapath: address, captured play, latched limit and per-play timeout counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_endereco <= '0;
            db_jogada    <= '0;
            cnt          <= '0;
            limite_q     <= '0;
        end else begin
            case (state)
                PREPARA: begin
                    mem_endereco <= '0;
                    db_jogada    <= '0;
                    cnt          <= '0;
                    limite_q     <= limite;
                end
                ESPERA: begin
                    if (!jogada_edge && !counter_done) cnt <= cnt + CNT_W'(1);
                end
                REGISTRA: db_jogada <= chaves;
                PROXIMO: begin
                    mem_endereco <= mem_endereco + ADDR_W'(1);
                    cnt          <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
